counter_sequencer: RTL and testbench

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_sequencer.sv | 129 ++++++++++++
 tb/tb_counter_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Control FSM for a two-digit BCD stopwatch: paces increment strobes to the
// counter datapath and drives the display with optional lap freeze.
module counter_sequencer #(
  parameter logic [23:0] TICK_DIV = 24'd8388608,
  parameter bit          WRAP     = 1'b1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  input  logic [3:0] ones_in,
  input  logic [3:0] tens_in,
  output logic       cnt_inc,
  output logic       cnt_clr,
  output logic [3:0] disp_ones,
  output logic [3:0] disp_tens,
  output logic       running,
  output logic       lap_active,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e      state_q, state_d;
  logic [23:0] presc_q, presc_d;
  logic        cnt_inc_q, cnt_inc_d;
  logic        cnt_clr_q, cnt_clr_d;
  logic        lap_active_q, lap_active_d;
  logic [3:0]  lap_ones_q, lap_ones_d;
  logic [3:0]  lap_tens_q, lap_tens_d;
  logic [3:0]  disp_ones_q, disp_ones_d;
  logic [3:0]  disp_tens_q, disp_tens_d;
  logic        running_q, running_d;
  logic        done_q, done_d;
  logic        terminal;

  assign terminal = (ones_in == 4'd9) && (tens_in == 4'd9);

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    cnt_inc_d    = 1'b0;
    cnt_clr_d    = 1'b0;
    lap_active_d = lap_active_q;
    lap_ones_d   = lap_ones_q;
    lap_tens_d   = lap_tens_q;

    // clear > start_stop > lap; a lower-priority pulse in the same cycle is lost
    if (clear) begin
      state_d      = StIdle;
      presc_d      = '0;
      lap_active_d = 1'b0;
      cnt_clr_d    = 1'b1;
    end else if (start_stop) begin
      unique case (state_q)
        StIdle: begin
          state_d = StRun;
          presc_d = '0;
        end
        StRun:   state_d = StPause;
        StPause: state_d = StRun;
        default: state_d = state_q;
      endcase
    end else begin
      if (state_q == StRun) begin
        if (presc_q == TICK_DIV - 24'd1) begin
          presc_d = '0;
          if (terminal && !WRAP) begin
            state_d = StDone;
          end else begin
            cnt_inc_d = 1'b1;
          end
        end else begin
          presc_d = presc_q + 24'd1;
        end
      end
      if (lap && (state_q == StRun || state_q == StPause)) begin
        lap_active_d = !lap_active_q;
        if (!lap_active_q) begin
          lap_ones_d = ones_in;
          lap_tens_d = tens_in;
        end
      end
    end

    disp_ones_d = lap_active_d ? lap_ones_d : ones_in;
    disp_tens_d = lap_active_d ? lap_tens_d : tens_in;
    running_d   = (state_d == StRun);
    done_d      = (state_d == StDone);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      cnt_inc_q    <= 1'b0;
      cnt_clr_q    <= 1'b1;
      lap_active_q <= 1'b0;
      lap_ones_q   <= '0;
      lap_tens_q   <= '0;
      disp_ones_q  <= '0;
      disp_tens_q  <= '0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      cnt_inc_q    <= cnt_inc_d;
      cnt_clr_q    <= cnt_clr_d;
      lap_active_q <= lap_active_d;
      lap_ones_q   <= lap_ones_d;
      lap_tens_q   <= lap_tens_d;
      disp_ones_q  <= disp_ones_d;
      disp_tens_q  <= disp_tens_d;
      running_q    <= running_d;
      done_q       <= done_d;
    end
  end

  assign cnt_inc    = cnt_inc_q;
  assign cnt_clr    = cnt_clr_q;
  assign disp_ones  = disp_ones_q;
  assign disp_tens  = disp_tens_q;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign done       = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: a WRAP=1 and a WRAP=0 instance share stimulus and are
// checked every cycle against a behavioural stopwatch model, plus directed literal checks.
module tb_counter_sequencer;

  localparam int TickDiv = 4;
  localparam int MIdle = 0, MRun = 1, MPause = 2, MDone = 3;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic [3:0] ones_in = 4'd0, tens_in = 4'd0;

  logic       w_inc, w_clr, w_run, w_lap, w_done;
  logic [3:0] w_do, w_dt;
  logic       s_inc, s_clr, s_run, s_lap, s_done;
  logic [3:0] s_do, s_dt;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  always #5 clock = ~clock;

  counter_sequencer #(.TICK_DIV(24'(TickDiv)), .WRAP(1'b1)) u_dut_wrap (
    .clock(clock), .resetn(resetn), .start_stop(start_stop), .lap(lap), .clear(clear),
    .ones_in(ones_in), .tens_in(tens_in), .cnt_inc(w_inc), .cnt_clr(w_clr),
    .disp_ones(w_do), .disp_tens(w_dt), .running(w_run), .lap_active(w_lap), .done(w_done)
  );

  counter_sequencer #(.TICK_DIV(24'(TickDiv)), .WRAP(1'b0)) u_dut_stop (
    .clock(clock), .resetn(resetn), .start_stop(start_stop), .lap(lap), .clear(clear),
    .ones_in(ones_in), .tens_in(tens_in), .cnt_inc(s_inc), .cnt_clr(s_clr),
    .disp_ones(s_do), .disp_tens(s_dt), .running(s_run), .lap_active(s_lap), .done(s_done)
  );

  // Stopwatch as the user sees it: a mode, run cycles elapsed since the last tick,
  // and a frozen snapshot of the digits.
  typedef struct {
    int         mode;
    int         elapsed;
    bit         frozen;
    logic [3:0] snap_o, snap_t;
    logic       inc, clr;
    logic [3:0] d_o, d_t;
  } mdl_t;

  mdl_t m_w, m_s;

  function automatic mdl_t model_next(mdl_t s, bit wrap, bit rst_n, bit ss, bit lp, bit cl,
                                      logic [3:0] o, logic [3:0] t);
    mdl_t n;
    n = s;
    n.inc = 1'b0;
    n.clr = cl;
    if (!rst_n) begin
      n.mode = MIdle; n.elapsed = 0; n.frozen = 1'b0; n.snap_o = 0; n.snap_t = 0;
      n.clr = 1'b1; n.d_o = 0; n.d_t = 0;
      return n;
    end
    if (cl) begin
      n.mode = MIdle; n.elapsed = 0; n.frozen = 1'b0;
    end else if (ss) begin
      if (s.mode == MIdle) begin
        n.mode = MRun; n.elapsed = 0;
      end else if (s.mode == MRun) begin
        n.mode = MPause;
      end else if (s.mode == MPause) begin
        n.mode = MRun;
      end
    end else begin
      if (s.mode == MRun) begin
        n.elapsed = s.elapsed + 1;
        if (n.elapsed == TickDiv) begin
          n.elapsed = 0;
          if (o == 4'd9 && t == 4'd9 && !wrap) n.mode = MDone;
          else n.inc = 1'b1;
        end
      end
      if (lp && (s.mode == MRun || s.mode == MPause)) begin
        n.frozen = !s.frozen;
        if (n.frozen) begin
          n.snap_o = o; n.snap_t = t;
        end
      end
    end
    n.d_o = n.frozen ? n.snap_o : o;
    n.d_t = n.frozen ? n.snap_t : t;
    return n;
  endfunction

  function automatic logic [13:0] expect_vec(mdl_t m);
    return {m.inc, m.clr, m.d_t, m.d_o, m.mode == MRun, m.frozen, m.mode == MDone};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clock) begin
    m_w <= model_next(m_w, 1'b1, resetn, start_stop, lap, clear, ones_in, tens_in);
    m_s <= model_next(m_s, 1'b0, resetn, start_stop, lap, clear, ones_in, tens_in);
  end

  always @(negedge clock) begin
    if (check_en) begin
      chk("model_wrap", 32'({w_inc, w_clr, w_dt, w_do, w_run, w_lap, w_done}),
          32'(expect_vec(m_w)));
      chk("model_stop", 32'({s_inc, s_clr, s_dt, s_do, s_run, s_lap, s_done}),
          32'(expect_vec(m_s)));
    end
  end

  task automatic cyc(bit ss, bit lp, bit cl);
    start_stop = ss; lap = lp; clear = cl;
    @(posedge clock);
    #1;
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
  endtask

  initial begin
    bit seen;
    // Reset
    resetn = 1'b0;
    cyc(0, 0, 0);
    check_en = 1'b1;
    cyc(0, 0, 0);
    chk("reset_clr", 32'(w_clr), 1);
    chk("reset_outs", 32'({w_inc, w_run, w_lap, w_done, w_do, w_dt}), 0);
    resetn = 1'b1;
    cyc(0, 0, 0);
    chk("clr_release", 32'(w_clr), 0);

    // Start at edge k: ticks after k+4, k+8, k+12
    cyc(1, 0, 0);
    chk("running_after_start", 32'(w_run), 1);
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 0, 0);
      chk($sformatf("tick_k+%0d", i), 32'(w_inc), 32'((i % 4) == 0));
    end

    // Pause with two run cycles elapsed, resume: tick after exactly two more run cycles
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("paused", 32'(w_run), 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0);
    chk("pause_no_inc", 32'(w_inc), 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("resume_1", 32'(w_inc), 0);
    cyc(0, 0, 0);
    chk("resume_2", 32'(w_inc), 1);

    // Lap freeze while live digits move on
    ones_in = 4'd3; tens_in = 4'd7;
    cyc(0, 1, 0);
    chk("lap_set", 32'({w_lap, w_dt, w_do}), 32'({1'b1, 4'd7, 4'd3}));
    ones_in = 4'd5;
    cyc(0, 0, 0);
    chk("lap_frozen", 32'({w_dt, w_do}), 32'({4'd7, 4'd3}));
    cyc(0, 1, 0);
    chk("lap_release", 32'({w_lap, w_dt, w_do}), 32'({1'b0, 4'd7, 4'd5}));

    // Terminal 9/9: WRAP=1 increments, WRAP=0 stops in DONE
    ones_in = 4'd9; tens_in = 4'd9;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      cyc(0, 0, 0);
      if (s_done) seen = 1'b1;
    end
    chk("done_reached", 32'(seen), 1);
    chk("term_stop", 32'({s_inc, s_run, s_done}), 32'(3'b001));
    chk("term_wrap_inc", 32'(w_inc), 1);
    cyc(1, 0, 0);
    chk("done_ignores_ss", 32'({s_done, s_run}), 32'(2'b10));
    cyc(0, 0, 1);
    chk("done_clear", 32'({s_clr, s_done, s_run}), 32'(3'b100));
    cyc(0, 0, 0);
    chk("clear_one_cycle", 32'(s_clr), 0);
    ones_in = 4'd0; tens_in = 4'd0;

    // clear + start_stop + lap together in RUN
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("combo_lap_set", 32'(w_lap), 1);
    cyc(1, 1, 1);
    chk("combo", 32'({w_run, w_clr, w_lap, w_inc}), 32'(4'b0100));
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0);
      if (w_inc) seen = 1'b1;
    end
    chk("combo_no_inc", 32'(seen), 0);

    // Reset mid-run with three run cycles elapsed: pending tick is dropped
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    resetn = 1'b0;
    cyc(0, 0, 0);
    chk("midrun_reset", 32'({w_clr, w_inc, w_run, w_lap, w_done, w_do, w_dt}), 32'(1 << 12));
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0);
      if (w_inc) seen = 1'b1;
    end
    chk("after_reset_no_inc", 32'(seen), 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        ones_in = 4'd9; tens_in = 4'd9;
      end else begin
        ones_in = 4'($urandom_range(0, 9)); tens_in = 4'($urandom_range(0, 9));
      end
      resetn = ($urandom_range(0, 299) != 0);
      cyc($urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
    end
    resetn = 1'b1;
    cyc(0, 0, 0);
    @(negedge clock);
    check_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
